// File: rtl/cio_stdin_rx_pkg.sv
// Shared constants and helpers for the DPC console-input path: keyboard
// key indices, key-to-ASCII mapping and the echo strobe state encoding.
package cio_stdin_rx_pkg;

    // Panel key indices. Digits occupy 0..9 and letters A..Z occupy 10..35.
    localparam logic [7:0] KEYBOARD_DIGIT_0  = 8'd0;
    localparam logic [7:0] KEYBOARD_LETTER_A = 8'd10;
    localparam logic [7:0] KEYBOARD_SPACE    = 8'd36;
    localparam logic [7:0] KEYBOARD_ENTER    = 8'd37;
    // Control keys are consumed elsewhere in the emulator and never
    // produce console input. CIO and HARD_RST sit on the extended panel,
    // beyond the 40-key console vector.
    localparam logic [7:0] KEYBOARD_IRAM     = 8'd38;
    localparam logic [7:0] KEYBOARD_DRAM     = 8'd39;
    localparam logic [7:0] KEYBOARD_CIO      = 8'd40;
    localparam logic [7:0] KEYBOARD_HARD_RST = 8'd41;

    typedef enum logic [1:0] {
        E_IDLE = 2'd0,
        E_HIGH = 2'd1,
        E_LOW  = 2'd2
    } echo_state_t;

    typedef struct packed {
        logic       valid;
        logic [7:0] code;
    } key_code_t;

    // Map a key index to its ASCII code; control and unused keys are invalid.
    function automatic key_code_t key_to_ascii(input logic [7:0] key_idx);
        key_code_t res;
        res.valid = 1'b0;
        res.code  = 8'h00;
        if ((key_idx == KEYBOARD_IRAM) || (key_idx == KEYBOARD_DRAM) ||
            (key_idx == KEYBOARD_CIO)  || (key_idx == KEYBOARD_HARD_RST)) begin
            res.valid = 1'b0;
            res.code  = 8'h00;
        end else if (key_idx < KEYBOARD_LETTER_A) begin
            res.valid = 1'b1;
            res.code  = 8'h30 + (key_idx - KEYBOARD_DIGIT_0);
        end else if (key_idx < KEYBOARD_SPACE) begin
            res.valid = 1'b1;
            res.code  = 8'h41 + (key_idx - KEYBOARD_LETTER_A);
        end else if (key_idx == KEYBOARD_SPACE) begin
            res.valid = 1'b1;
            res.code  = 8'h20;
        end else if (key_idx == KEYBOARD_ENTER) begin
            res.valid = 1'b1;
            res.code  = 8'h0A;
        end else begin
            res.valid = 1'b0;
            res.code  = 8'h00;
        end
        return res;
    endfunction

endpackage

// File: rtl/cio_stdin_rx_fifo.sv
// Small synchronous FIFO with a registered head word, occupancy count and
// simultaneous push/pop (a push into a full FIFO succeeds if a pop happens
// in the same cycle). Shared with the console-output path.
module cio_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   vld,
    output logic                   full,
    output logic                   push_ok,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [AW:0]      level_r;
    logic [WIDTH-1:0] head_r;
    logic             vld_r;

    logic [AW:0]      wr_ptr_next_s;
    logic [AW:0]      rd_ptr_next_s;
    logic [AW:0]      level_next_s;
    logic [WIDTH-1:0] head_next_s;
    logic             pop_s;
    logic             push_s;
    logic             full_s;

    // Accept/advance decisions and the head word seen after this edge.
    always_comb begin
        full_s        = (level_r == FULL_LEVEL);
        pop_s         = pop & vld_r;
        push_s        = push & (~full_s | pop_s);
        wr_ptr_next_s = wr_ptr_r + {{AW{1'b0}}, push_s};
        rd_ptr_next_s = rd_ptr_r + {{AW{1'b0}}, pop_s};
        level_next_s  = level_r + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
        if (level_next_s == {(AW+1){1'b0}}) begin
            head_next_s = {WIDTH{1'b0}};
        end else if (rd_ptr_next_s == wr_ptr_r) begin
            // New head is the word being written this cycle.
            head_next_s = din;
        end else begin
            head_next_s = mem_r[rd_ptr_next_s[AW-1:0]];
        end
    end

    // Storage array; contents need no reset since head logic masks empties.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
        end
    end

    // Pointers, occupancy and registered head/valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
            level_r  <= {(AW+1){1'b0}};
            head_r   <= {WIDTH{1'b0}};
            vld_r    <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_next_s;
            rd_ptr_r <= rd_ptr_next_s;
            level_r  <= level_next_s;
            head_r   <= head_next_s;
            vld_r    <= (level_next_s != {(AW+1){1'b0}});
        end
    end

    assign dout    = head_r;
    assign vld     = vld_r;
    assign full    = full_s;
    assign push_ok = push_s;
    assign level   = level_r;

endmodule

// File: rtl/cio_stdin_rx.sv
// Console-input receiver: debounces the key panel, picks the lowest newly
// pressed key, maps it to ASCII, queues it for the DPC read-stdin
// instruction and optionally echoes it with a slow strobe the console RAM
// writer can see. All state advances on the falling edge of the 1 us clock.
module cio_stdin_rx
    import cio_stdin_rx_pkg::*;
#(
    parameter int KEYS            = 40,
    parameter int FIFO_DEPTH      = 8,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int ECHO_HOLD       = 2000
) (
    input  logic                        Clock_1us,
    input  logic                        Rst,
    input  logic [KEYS-1:0]             keysCurrentState,
    input  logic                        echo_en,
    output logic [7:0]                  rx_data,
    output logic                        rx_vld,
    input  logic                        rx_ack,
    output logic [7:0]                  tx_data,
    output logic                        tx_vld,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES);
    localparam int EW  = $clog2(ECHO_HOLD) + 1;
    localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [EW-1:0]  ECHO_LAST = EW'(ECHO_HOLD - 1);

    // The FIFO runs on the emulator's falling-edge domain.
    logic clk_s;
    assign clk_s = ~Clock_1us;

    logic [KEYS-1:0] sample_r;
    logic [KEYS-1:0] stable_r;
    logic [DBW-1:0]  db_cnt_r;
    logic [KEYS-1:0] stable_next_s;
    logic [KEYS-1:0] new_s;
    logic            db_done_s;

    logic            hit_s;
    logic [7:0]      idx_s;
    key_code_t       map_s;
    logic            push_req_s;
    logic            push_ok_s;
    logic            fifo_full_s;

    echo_state_t     state_r;
    echo_state_t     state_next_s;
    logic [EW-1:0]   echo_cnt_r;
    logic [EW-1:0]   echo_cnt_next_s;
    logic            tx_vld_r;
    logic            tx_vld_next_s;
    logic [7:0]      tx_data_r;
    logic [7:0]      tx_data_next_s;
    logic            overflow_r;

    // Debounced vector for this edge and the rising edges it creates.
    always_comb begin
        db_done_s     = (keysCurrentState == sample_r) && (db_cnt_r == DB_LAST);
        stable_next_s = db_done_s ? sample_r : stable_r;
        new_s         = stable_next_s & ~stable_r;
    end

    // Debounce: restart on any change, accept once the vector has held.
    always_ff @(negedge Clock_1us) begin
        if (Rst) begin
            sample_r <= keysCurrentState;
            stable_r <= keysCurrentState;
            db_cnt_r <= {DBW{1'b0}};
        end else if (keysCurrentState != sample_r) begin
            sample_r <= keysCurrentState;
            db_cnt_r <= {DBW{1'b0}};
        end else if (db_cnt_r == DB_LAST) begin
            stable_r <= sample_r;
        end else begin
            db_cnt_r <= db_cnt_r + {{(DBW-1){1'b0}}, 1'b1};
        end
    end

    // Lowest-index new press wins; other simultaneous presses are dropped.
    always_comb begin
        hit_s = 1'b0;
        idx_s = 8'd0;
        for (int i = KEYS - 1; i >= 0; i--) begin
            if (new_s[i]) begin
                hit_s = 1'b1;
                idx_s = 8'(i);
            end else begin
                hit_s = hit_s;
            end
        end
        map_s      = key_to_ascii(idx_s);
        push_req_s = hit_s & map_s.valid;
    end

    cio_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_s),
        .rst     (Rst),
        .push    (push_req_s),
        .din     (map_s.code),
        .pop     (rx_ack),
        .dout    (rx_data),
        .vld     (rx_vld),
        .full    (fifo_full_s),
        .push_ok (push_ok_s),
        .level   (fifo_level)
    );

    // Sticky overflow: a character was lost because the FIFO stayed full.
    always_ff @(negedge Clock_1us) begin
        if (Rst) begin
            overflow_r <= 1'b0;
        end else if (push_req_s && !push_ok_s && fifo_full_s) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    // Echo FSM state register together with its hold counter and outputs.
    always_ff @(negedge Clock_1us) begin
        if (Rst) begin
            state_r    <= E_IDLE;
            echo_cnt_r <= {EW{1'b0}};
            tx_vld_r   <= 1'b0;
            tx_data_r  <= 8'h00;
        end else begin
            state_r    <= state_next_s;
            echo_cnt_r <= echo_cnt_next_s;
            tx_vld_r   <= tx_vld_next_s;
            tx_data_r  <= tx_data_next_s;
        end
    end

    // Echo FSM next state: start on an accepted push, then high and low holds.
    always_comb begin
        state_next_s    = state_r;
        echo_cnt_next_s = echo_cnt_r;
        case (state_r)
            E_IDLE: begin
                if (push_ok_s && echo_en) begin
                    state_next_s    = E_HIGH;
                    echo_cnt_next_s = {EW{1'b0}};
                end else begin
                    state_next_s    = E_IDLE;
                end
            end
            E_HIGH: begin
                if (echo_cnt_r == ECHO_LAST) begin
                    state_next_s    = E_LOW;
                    echo_cnt_next_s = {EW{1'b0}};
                end else begin
                    echo_cnt_next_s = echo_cnt_r + {{(EW-1){1'b0}}, 1'b1};
                end
            end
            E_LOW: begin
                if (echo_cnt_r == ECHO_LAST) begin
                    state_next_s    = E_IDLE;
                    echo_cnt_next_s = {EW{1'b0}};
                end else begin
                    echo_cnt_next_s = echo_cnt_r + {{(EW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_next_s    = E_IDLE;
                echo_cnt_next_s = {EW{1'b0}};
            end
        endcase
    end

    // Echo FSM outputs: strobe follows E_HIGH, data latched when an echo starts.
    always_comb begin
        tx_vld_next_s = (state_next_s == E_HIGH);
        if ((state_r == E_IDLE) && (state_next_s == E_HIGH)) begin
            tx_data_next_s = map_s.code;
        end else begin
            tx_data_next_s = tx_data_r;
        end
    end

    assign tx_vld   = tx_vld_r;
    assign tx_data  = tx_data_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_cio_stdin_rx.sv
// Bench for cio_stdin_rx with shortened debounce/echo times. Expected codes
// come from the key-mapping rules; queued characters are modelled by a queue.
module tb_cio_stdin_rx;

    localparam int KEYS  = 40;
    localparam int DEPTH = 8;
    localparam int DB    = 20;
    localparam int EH    = 40;

    logic            clk = 1'b0;
    logic            rst;
    logic [KEYS-1:0] keys;
    logic            echo_en;
    logic            rx_ack;
    logic [7:0]      rx_data;
    logic            rx_vld;
    logic [7:0]      tx_data;
    logic            tx_vld;
    logic            overflow;
    logic [3:0]      fifo_level;

    int errors = 0;
    int checks = 0;
    int q[$];

    always #5 clk = ~clk;

    cio_stdin_rx #(
        .KEYS            (KEYS),
        .FIFO_DEPTH      (DEPTH),
        .DEBOUNCE_CYCLES (DB),
        .ECHO_HOLD       (EH)
    ) dut (
        .Clock_1us        (clk),
        .Rst              (rst),
        .keysCurrentState (keys),
        .echo_en          (echo_en),
        .rx_data          (rx_data),
        .rx_vld           (rx_vld),
        .rx_ack           (rx_ack),
        .tx_data          (tx_data),
        .tx_vld           (tx_vld),
        .overflow         (overflow),
        .fifo_level       (fifo_level)
    );

    // ASCII for a key index, or -1 when the key produces no character.
    function automatic int exp_code(input int k);
        if (k < 10)  return 48 + k;
        if (k < 36)  return 65 + (k - 10);
        if (k == 36) return 32;
        if (k == 37) return 10;
        return -1;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Press and release one key with full settle time; update the model.
    task automatic press_key(input int k);
        int c;
        keys[k] = 1'b1;
        tick(DB + 2);
        keys[k] = 1'b0;
        tick(DB + 2);
        c = exp_code(k);
        if (c >= 0 && q.size() < DEPTH) q.push_back(c);
        checks++;
        if (fifo_level !== 4'(q.size())) begin
            errors++;
            $display("FAIL press_level key=%0d: got %0d want %0d", k, fifo_level, q.size());
        end
    endtask

    task automatic test_reset();
        keys = '0;
        keys[3] = 1'b1;
        rst = 1'b1;
        tick(2);
        checks++;
        if ({rx_vld, tx_vld, overflow} !== 3'b000 || rx_data !== 8'h00 ||
            tx_data !== 8'h00 || fifo_level !== 4'd0) begin
            errors++;
            $display("FAIL reset_state: got vld=%b tx=%b ovf=%b rx=%h txd=%h lvl=%0d want all zero",
                     rx_vld, tx_vld, overflow, rx_data, tx_data, fifo_level);
        end
        rst = 1'b0;
        tick(DB + 2);
        keys[3] = 1'b0;
        tick(2 * DB);
        checks++;
        if (rx_vld !== 1'b0 || fifo_level !== 4'd0) begin
            errors++;
            $display("FAIL held_through_reset: got vld=%b lvl=%0d want 0 0", rx_vld, fifo_level);
        end
    endtask

    task automatic test_bounce();
        keys[5] = 1'b1;
        for (int b = 0; b < 3; b++) begin
            tick($urandom_range(2, 10));
            keys[5] = 1'b0;
            tick($urandom_range(2, 10));
            keys[5] = 1'b1;
        end
        tick(DB);
        checks++;
        if (rx_vld !== 1'b0) begin
            errors++;
            $display("FAIL bounce_early: got vld=%b want 0", rx_vld);
        end
        tick(1);
        checks++;
        if (rx_vld !== 1'b1 || rx_data !== 8'h35) begin
            errors++;
            $display("FAIL bounce_push: got vld=%b data=%h want 1 35", rx_vld, rx_data);
        end
        tick(5);
        checks++;
        if (fifo_level !== 4'd1) begin
            errors++;
            $display("FAIL bounce_once: got lvl=%0d want 1", fifo_level);
        end
        rx_ack = 1'b1;
        tick(1);
        rx_ack = 1'b0;
        checks++;
        if (rx_vld !== 1'b0) begin
            errors++;
            $display("FAIL bounce_ack: got vld=%b want 0", rx_vld);
        end
        keys[5] = 1'b0;
        tick(DB + 2);
        checks++;
        if (fifo_level !== 4'd0) begin
            errors++;
            $display("FAIL release_ignored: got lvl=%0d want 0", fifo_level);
        end
    endtask

    task automatic test_simultaneous();
        for (int it = 0; it < 3; it++) begin
            int a;
            int b;
            if (it == 0) begin
                a = 12;
                b = 20;
            end else begin
                a = $urandom_range(0, 36);
                b = $urandom_range(a + 1, 37);
            end
            keys[a] = 1'b1;
            keys[b] = 1'b1;
            tick(DB + 2);
            keys[a] = 1'b0;
            keys[b] = 1'b0;
            tick(DB + 2);
            checks++;
            if (fifo_level !== 4'd1 || rx_data !== 8'(exp_code(a))) begin
                errors++;
                $display("FAIL simultaneous %0d+%0d: got lvl=%0d data=%h want 1 %h",
                         a, b, fifo_level, rx_data, 8'(exp_code(a)));
            end
            rx_ack = 1'b1;
            tick(1);
            rx_ack = 1'b0;
        end
    endtask

    task automatic test_invalid_keys();
        press_key(38);
        press_key(39);
        rx_ack = 1'b1;
        tick(1);
        rx_ack = 1'b0;
        checks++;
        if (fifo_level !== 4'd0 || rx_vld !== 1'b0) begin
            errors++;
            $display("FAIL ack_empty: got lvl=%0d vld=%b want 0 0", fifo_level, rx_vld);
        end
    endtask

    task automatic test_overflow();
        int perm[38];
        int tmp;
        int j;
        int k;
        for (int i = 0; i < 38; i++) perm[i] = i;
        for (int i = 37; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = perm[i];
            perm[i] = perm[j];
            perm[j] = tmp;
        end
        for (int i = 0; i < 9; i++) press_key(perm[i]);
        checks++;
        if (fifo_level !== 4'd8 || overflow !== 1'b1 || rx_data !== 8'(q[0])) begin
            errors++;
            $display("FAIL overflow: got lvl=%0d ovf=%b head=%h want 8 1 %h",
                     fifo_level, overflow, rx_data, 8'(q[0]));
        end
        // Push into the full FIFO on the same edge as a pop.
        k = perm[9];
        keys[k] = 1'b1;
        tick(DB);
        rx_ack = 1'b1;
        tick(1);
        rx_ack = 1'b0;
        void'(q.pop_front());
        q.push_back(exp_code(k));
        checks++;
        if (fifo_level !== 4'd8 || rx_data !== 8'(q[0])) begin
            errors++;
            $display("FAIL full_push_pop: got lvl=%0d head=%h want 8 %h",
                     fifo_level, rx_data, 8'(q[0]));
        end
        keys[k] = 1'b0;
        tick(DB + 2);
        for (int n = 0; n < 8; n++) begin
            checks++;
            if (rx_vld !== 1'b1 || rx_data !== 8'(q[0])) begin
                errors++;
                $display("FAIL drain[%0d]: got vld=%b data=%h want 1 %h",
                         n, rx_vld, rx_data, 8'(q[0]));
            end
            rx_ack = 1'b1;
            tick(1);
            rx_ack = 1'b0;
            void'(q.pop_front());
        end
        checks++;
        if (rx_vld !== 1'b0 || fifo_level !== 4'd0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL drained: got vld=%b lvl=%0d ovf=%b want 0 0 1",
                     rx_vld, fifo_level, overflow);
        end
    endtask

    task automatic test_reset_mid();
        int a;
        int b;
        int c;
        a = $urandom_range(0, 9);
        b = $urandom_range(10, 19);
        c = $urandom_range(20, 29);
        echo_en = 1'b0;
        press_key(a);
        press_key(b);
        echo_en = 1'b1;
        keys[c] = 1'b1;
        tick(DB + 1);
        checks++;
        if (tx_vld !== 1'b1 || fifo_level !== 4'd3) begin
            errors++;
            $display("FAIL pre_reset: got tx=%b lvl=%0d want 1 3", tx_vld, fifo_level);
        end
        keys[31] = 1'b1;
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        q.delete();
        checks++;
        if (rx_vld !== 1'b0 || tx_vld !== 1'b0 || fifo_level !== 4'd0 ||
            overflow !== 1'b0 || tx_data !== 8'h00 || rx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid: got vld=%b tx=%b lvl=%0d ovf=%b txd=%h rx=%h want zeros",
                     rx_vld, tx_vld, fifo_level, overflow, tx_data, rx_data);
        end
        tick(DB + 2);
        checks++;
        if (fifo_level !== 4'd0) begin
            errors++;
            $display("FAIL pending_dropped: got lvl=%0d want 0", fifo_level);
        end
        keys = '0;
        tick(DB + 2);
        echo_en = 1'b0;
    endtask

    task automatic test_echo();
        int k2;
        int k3;
        int hi;
        bit extra;
        k2 = $urandom_range(0, 35);
        k3 = $urandom_range(0, 37);
        echo_en = 1'b1;
        keys[36] = 1'b1;
        tick(DB + 1);
        q.push_back(32);
        checks++;
        if (tx_vld !== 1'b1 || tx_data !== 8'h20) begin
            errors++;
            $display("FAIL echo_start: got tx=%b data=%h want 1 20", tx_vld, tx_data);
        end
        hi = 1;
        keys[36] = 1'b0;
        keys[k2] = 1'b1;
        for (int t = 0; t < 3 * EH && tx_vld === 1'b1; t++) begin
            tick(1);
            if (tx_vld === 1'b1) hi++;
        end
        q.push_back(exp_code(k2));
        checks++;
        if (hi != EH) begin
            errors++;
            $display("FAIL echo_width: got %0d cycles want %0d", hi, EH);
        end
        checks++;
        if (fifo_level !== 4'd2 || tx_data !== 8'h20) begin
            errors++;
            $display("FAIL echo_queue: got lvl=%0d txd=%h want 2 20", fifo_level, tx_data);
        end
        extra = 1'b0;
        for (int t = 0; t < 2 * EH; t++) begin
            tick(1);
            if (tx_vld !== 1'b0) extra = 1'b1;
        end
        checks++;
        if (extra) begin
            errors++;
            $display("FAIL echo_second: got tx_vld=1 after first echo want 0");
        end
        keys[k2] = 1'b0;
        tick(DB + 2);
        for (int n = 0; n < 2; n++) begin
            checks++;
            if (rx_data !== 8'(q[0])) begin
                errors++;
                $display("FAIL echo_drain[%0d]: got %h want %h", n, rx_data, 8'(q[0]));
            end
            rx_ack = 1'b1;
            tick(1);
            rx_ack = 1'b0;
            void'(q.pop_front());
        end
        keys[k3] = 1'b1;
        tick(DB + 1);
        checks++;
        if (tx_vld !== 1'b1 || tx_data !== 8'(exp_code(k3))) begin
            errors++;
            $display("FAIL echo_again key=%0d: got tx=%b data=%h want 1 %h",
                     k3, tx_vld, tx_data, 8'(exp_code(k3)));
        end
        keys[k3] = 1'b0;
        tick(2 * EH + DB);
        echo_en = 1'b0;
    endtask

    initial begin
        keys    = '0;
        rst     = 1'b1;
        echo_en = 1'b0;
        rx_ack  = 1'b0;
        test_reset();
        test_bounce();
        test_simultaneous();
        test_invalid_keys();
        test_overflow();
        test_reset_mid();
        test_echo();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cio_stdin_rx.md
# cio_stdin_rx

Console-input receiver for the DPC emulator: the input counterpart of the MS6205 console-output path. It debounces the 40-key panel state, edge-detects new presses, maps them to ASCII, and buffers them in a small FIFO for the DPC `,` (read stdin) instruction via a valid/ack handshake. It optionally echoes each accepted character onto a `tx_data`/`tx_vld` pair paced for the MS6205 console RAM writer. It sits between the keyboard scanner and the DPC core, with its echo output merged into the display's tx path.

## Interface
- `KEYS`, 40: width of key-state vector.
- `FIFO_DEPTH`, 8: receive FIFO entries; power of two, ≥2.
- `DEBOUNCE_CYCLES`, 1000: cycles a key vector must stay unchanged before acceptance (1 ms at 1 µs clock).
- `ECHO_HOLD`, 2000: cycles `tx_vld` is held high, then low, per echoed byte.

Ports:
- `Clock_1us`  in  1  sole clock; all logic on negedge, matching the emulator's 1 µs domain.
- `Rst`  in  1  reset; one clock, reset is synchronous and active-high.
- `keysCurrentState`  in  KEYS  raw key levels, 1 = pressed.
- `echo_en`  in  1  enable echo of accepted characters.
- `rx_data`  out  8  ASCII code at FIFO head.
- `rx_vld`  out  1  FIFO non-empty.
- `rx_ack`  in  1  consumer pop; honoured only while `rx_vld`=1.
- `tx_data`  out  8  echo character.
- `tx_vld`  out  1  echo strobe.
- `overflow`  out  1  sticky: a character was dropped on full FIFO.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current occupancy.

## Operation
- Debounce: register `sample`, counter `db_cnt`. If `keysCurrentState != sample`: `sample <= keys`, `db_cnt <= 0`. Else if `db_cnt == DEBOUNCE_CYCLES-1`: `stable <= sample`, counter saturates. Else increment.
- Press detect: `new = stable_next & ~stable`, evaluated on the cycle `stable` updates. Only the lowest set index is used; other simultaneous presses are discarded. Releases are ignored.
- Mapping (`key_to_ascii`): keys 0–9 map to 0x30+i; keys 10–35 map to 0x41+(i−10); key 36 maps to 0x20; key 37 maps to 0x0A. Keys 38–39 and the package's IRAM/DRAM/CIO/HARD_RST control-key indices map to invalid and are never pushed.
- FIFO push: occurs on a valid mapped press. If full and no pop occurs that cycle: drop the character and set `overflow` (cleared only by `Rst`). Full with a simultaneous pop: both push and pop happen, and level is unchanged.
- Pop: `rx_ack & rx_vld` advances the head. `rx_ack` while empty has no effect.
- Echo FSM states: E_IDLE → E_HIGH → E_LOW → E_IDLE.
  - E_IDLE: a push with `echo_en`=1 latches `tx_data` and moves to E_HIGH with `tx_vld`=1.
  - E_HIGH: after ECHO_HOLD cycles, move to E_LOW with `tx_vld`=0.
  - E_LOW: after ECHO_HOLD cycles, return to E_IDLE.
  - A push while not E_IDLE is stored in the FIFO but not echoed. Echo never blocks the FIFO.
- Reset values:
  - `sample`, `stable` load current `keysCurrentState`, so keys held through reset generate no press.
  - `db_cnt`=0.
  - FIFO empty: `rx_vld`=0, `rx_data`=0x00, `fifo_level`=0.
  - Echo FSM in E_IDLE with `tx_vld`=0, `tx_data`=0x00.
  - `overflow`=0.
- Reset mid-operation flushes the FIFO, aborts the echo, and drops any pending debounce.

## Timing
- Press-to-push latency: the stable edge vector becomes valid DEBOUNCE_CYCLES cycles after the last input change, and the push occurs on the same edge as the `stable` update.
- `rx_vld` and `rx_data` are registered: both are valid one cycle after the push into an empty FIFO. `rx_data` updates one cycle after a pop.
- `tx_vld` rises one cycle after the push and stays high exactly ECHO_HOLD cycles. The minimum spacing between echoes is 2·ECHO_HOLD cycles, which guarantees the 1 ms display clock sees both levels.
- Counter widths are `$clog2(DEBOUNCE_CYCLES)` and `$clog2(ECHO_HOLD)+1`. The pointers wrap modulo FIFO_DEPTH, with an extra MSB for full/empty detection.

## Structure
- Shared package (alongside the existing DPC keyboard constants):
  - `KEYBOARD_*` key indices.
  - `key_to_ascii` function returning {valid, code[7:0]}.
  - Echo FSM state enum typedef.
- Sub-module `cio_sync_fifo` (parameters WIDTH, DEPTH): registered head output, level, full/empty, simultaneous push/pop. Reusable for the stdout path.
- Top level contains the debounce, priority encoder, mapping, echo FSM and overflow flag.

## Test plan
- Reset with key 3 held; release; wait 2·DEBOUNCE_CYCLES → no push, `rx_vld`=0.
- Press key 5 (bounce 3 times within 100 cycles, then hold) → exactly one 0x35. `rx_vld` rises DEBOUNCE_CYCLES+1 cycles after the last bounce. Pulsing `rx_ack` clears `rx_vld`.
- Keys 12 and 20 pressed in the same cycle → only 0x43 pushed.
- Nine distinct presses with no ack at FIFO_DEPTH=8 → `fifo_level`=8 and `overflow`=1. Draining yields the first eight codes in order.
- `echo_en`=1, key 36 → `tx_data`=0x20 and `tx_vld` high exactly ECHO_HOLD cycles. A second press during E_HIGH is queued in the FIFO but produces no second echo.
- Assert `Rst` while FIFO holds 3 and `tx_vld`=1 → next cycle `rx_vld`=0, `tx_vld`=0, `fifo_level`=0, `overflow`=0.
